// File: rtl/spi_txn_arb.sv
// Round-robin arbiter/sequencer sharing one 16-bit SPI monarch between NUM_REQ clients.
// Optional WAIT-state timeout with sticky err: define SPI_ARB_TIMEOUT_EN.
module spi_txn_arb #(
  parameter int NUM_REQ = 2,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 2047
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   cmd_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      cmplt,
  output logic [15:0]             resp,
  output logic                    busy,
  output logic                    err,
  output logic                    spi_snd,
  output logic [15:0]             spi_cmd,
  input  logic                    spi_done,
  input  logic [15:0]             spi_resp
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYC < 1 || GAP_CYC > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("spi_txn_arb: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CMPLT, S_GAP} state_t;

  state_t              state;
  logic [IW-1:0]       rr_ptr, owner, win;
  logic                win_vld;
  logic [15:0]         win_cmd;
  logic [3:0]          gap_cnt;
  logic [NUM_REQ-1:0]  win_oh, own_oh;

  // Search upward from rr_ptr+1 with wrap; first requester found wins.
  always_comb begin
    int j;
    win     = rr_ptr;
    win_vld = 1'b0;
    win_cmd = 16'h0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win     = IW'(j);
        win_cmd = cmd_in[16*j +: 16];
      end
    end
  end

  assign win_oh = NUM_REQ'(1) << win;
  assign own_oh = NUM_REQ'(1) << owner;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      gnt     <= '0;
      cmplt   <= '0;
      resp    <= 16'h0;
      busy    <= 1'b0;
      spi_snd <= 1'b0;
      spi_cmd <= 16'h0;
      rr_ptr  <= IW'(NUM_REQ - 1);
      owner   <= '0;
      gap_cnt <= 4'h0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      spi_snd <= 1'b0;
      cmplt   <= '0;
      case (state)
        S_IDLE: if (win_vld) begin
          state   <= S_LAUNCH;
          spi_cmd <= win_cmd;
          gnt     <= win_oh;
          owner   <= win;
          spi_snd <= 1'b1;
          busy    <= 1'b1;
        end
        S_LAUNCH: begin
          state <= S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        // done seen here is fresh: the monarch dropped it when it took snd
        S_WAIT: begin
          if (spi_done) begin
            state  <= S_CMPLT;
            resp   <= spi_resp;
            cmplt  <= own_oh;
            rr_ptr <= owner;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state  <= S_CMPLT;
            resp   <= 16'hFFFF;
            cmplt  <= own_oh;
            rr_ptr <= owner;
            err_q  <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_CMPLT: begin
          state   <= S_GAP;
          gnt     <= '0;
          gap_cnt <= 4'(GAP_CYC - 1);
        end
        S_GAP: begin
          if (gap_cnt == 4'h0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'h1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arb.sv
// Directed bench for spi_txn_arb: transaction-timeline model checked every cycle,
// plus literal checks per scenario. Timeout scenario runs when SPI_ARB_TIMEOUT_EN is set.
module tb_spi_txn_arb;

  localparam int N   = 2;
  localparam int GAP = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO     = 100;
  localparam int T1_LAT = 80;
`else
  localparam int TO     = 2047;
  localparam int T1_LAT = 600;
`endif

  logic            clk, rst;
  logic [N-1:0]    req;
  logic [16*N-1:0] cmd_in;
  logic [N-1:0]    gnt, cmplt;
  logic [15:0]     resp, spi_cmd, spi_resp;
  logic            busy, err, spi_snd, spi_done;

  spi_txn_arb #(.NUM_REQ(N), .GAP_CYC(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in), .gnt(gnt), .cmplt(cmplt),
    .resp(resp), .busy(busy), .err(err), .spi_snd(spi_snd), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_resp(spi_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: each transaction is a set of cycle stamps (snd, cmplt, idle-again).
  int          m_cyc, m_snd, m_cmp, m_idle, m_own, m_ptr, m_w, m_p;
  bit          m_act, m_err;
  logic [15:0] m_resp, m_cmd;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cyc = 0; m_act = 0; m_snd = -1; m_cmp = -1; m_idle = 0;
        m_ptr = N - 1; m_own = 0; m_resp = 16'h0; m_cmd = 16'h0; m_err = 0;
      end else begin
        m_p = m_cyc;
        if (!m_act && m_p >= m_idle) begin
          m_w = -1;
          for (int k = 1; k <= N; k++)
            if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
          if (m_w >= 0) begin
            m_own = m_w; m_act = 1; m_snd = m_p + 1; m_cmd = cmd_in[16*m_w +: 16];
          end
        end else if (m_act && m_p > m_snd) begin
          if (spi_done) begin
            m_cmp = m_p + 1; m_resp = spi_resp; m_ptr = m_own; m_act = 0; m_idle = m_p + 2 + GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (m_p == m_snd + TO) begin
            m_cmp = m_p + 1; m_resp = 16'hFFFF; m_ptr = m_own; m_act = 0; m_idle = m_p + 2 + GAP;
            m_err = 1;
          end
`endif
        end
        m_cyc = m_p + 1;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    bit gon;
    forever begin
      @(negedge clk);
      if (!rst) begin
        gon = m_act ? (m_cyc >= m_snd) : (m_cyc == m_cmp);
        chk("cyc_gnt",   32'(gnt),     gon ? 32'(1 << m_own) : 32'h0);
        chk("cyc_cmplt", 32'(cmplt),   (m_cyc == m_cmp) ? 32'(1 << m_own) : 32'h0);
        chk("cyc_snd",   32'(spi_snd), 32'(m_cyc == m_snd));
        chk("cyc_busy",  32'(busy),    32'(m_act || m_cyc < m_idle));
        chk("cyc_resp",  32'(resp),    32'(m_resp));
        chk("cyc_cmd",   32'(spi_cmd), 32'(m_cmd));
        chk("cyc_err",   32'(err),     32'(m_err));
      end
    end
  end

  // Stimulus state: monarch model, auto-drop clients, event log.
  int   tcyc = 0, mcnt = 0, mon_lat = 5, done_cyc = 0;
  bit   mon_hang = 0, mon_fixed_en = 0, auto_drop = 0;
  logic [15:0] mon_fixed = 16'h0;
  int   snd_cnt = 0, cmp_cnt = 0, last_snd = 0, last_cmp = 0;
  int   own_q[$];
  logic [N-1:0] gnt_q[$];

  task automatic step();
    @(negedge clk);
    tcyc++;
    if (spi_snd) begin
      snd_cnt++; last_snd = tcyc; gnt_q.push_back(gnt);
      spi_done = 1'b0; mcnt = mon_lat;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0 && !mon_hang) begin
        spi_done = 1'b1;
        spi_resp = mon_fixed_en ? mon_fixed : spi_cmd + 16'h0101;
        done_cyc = tcyc;
      end
    end
    for (int i = 0; i < N; i++)
      if (cmplt[i]) begin
        cmp_cnt++; last_cmp = tcyc; own_q.push_back(i);
        if (auto_drop) req[i] = 1'b0;
      end
  endtask

  task automatic wait_cmplt(input int budget, input string nm);
    int n = 0;
    do begin step(); n++; end while (cmplt == '0 && n < budget);
    chk(nm, 32'(cmplt != '0), 32'h1);
  endtask

  task automatic wait_snd(input int budget, input string nm);
    int n = 0;
    do begin step(); n++; end while (!spi_snd && n < budget);
    chk(nm, 32'(spi_snd), 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1; mcnt = 0; spi_done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int c1, s0, o0, g0, r0, nc, ns;
    rst = 1'b1; req = '0; cmd_in = '0; spi_done = 1'b0; spi_resp = 16'h0;
    do_reset();
    chk("rst_gnt",  32'(gnt),     32'h0);
    chk("rst_busy", 32'(busy),    32'h0);
    chk("rst_resp", 32'(resp),    32'h0);
    chk("rst_cmd",  32'(spi_cmd), 32'h0);
    chk("rst_err",  32'(err),     32'h0);

    // 1: single client, long monarch latency
    cmd_in = {16'h0000, 16'h8F00};
    mon_fixed_en = 1; mon_fixed = 16'h00A5; mon_lat = T1_LAT; auto_drop = 1;
    req = 2'b01;
    step();
    chk("t1_snd", 32'(spi_snd), 32'h1);
    chk("t1_cmd", 32'(spi_cmd), 32'h8F00);
    chk("t1_gnt", 32'(gnt),     32'h1);
    wait_cmplt(T1_LAT + 50, "t1_cmplt_seen");
    chk("t1_cmplt",    32'(cmplt), 32'h1);
    chk("t1_resp",     32'(resp),  32'h00A5);
    chk("t1_done_lat", 32'(tcyc - done_cyc), 32'h1);
    chk("t1_snd_lat",  32'(tcyc - last_snd), 32'(T1_LAT + 1));
    repeat (GAP) step();
    chk("t1_busy_gap", 32'(busy), 32'h1);
    step();
    chk("t1_busy_idle", 32'(busy), 32'h0);

    // 2: both from reset, each held until its own cmplt
    do_reset();
    mon_fixed_en = 0; mon_lat = 5;
    cmd_in = {16'h2222, 16'h1111};
    s0 = snd_cnt; o0 = own_q.size();
    req = 2'b11;
    wait_cmplt(40, "t2_c0_seen");
    chk("t2_resp0", 32'(resp), 32'h1212);
    c1 = tcyc;
    wait_cmplt(40, "t2_c1_seen");
    chk("t2_resp1", 32'(resp), 32'h2323);
    chk("t2_own0", 32'(own_q[o0]),     32'h0);
    chk("t2_own1", 32'(own_q[o0 + 1]), 32'h1);
    chk("t2_gap",  32'(last_snd - c1), 32'(GAP + 2));
    repeat (GAP + 4) step();
    chk("t2_snds", 32'(snd_cnt - s0), 32'h2);
    chk("t2_idle", 32'(busy), 32'h0);

    // 3: both held permanently, alternation
    auto_drop = 0; g0 = gnt_q.size();
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_cmplt(40, "t3_seen");
    req = 2'b00;
    chk("t3_g0", 32'(gnt_q[g0]),     32'h1);
    chk("t3_g1", 32'(gnt_q[g0 + 1]), 32'h2);
    chk("t3_g2", 32'(gnt_q[g0 + 2]), 32'h1);
    chk("t3_g3", 32'(gnt_q[g0 + 3]), 32'h2);
    repeat (GAP + 3) step();

    // 4: reset during WAIT, then pending req[1]
    mon_lat = 50; req = 2'b01;
    wait_snd(20, "t4_snd_seen");
    repeat (3) step();
    #1 rst = 1'b1;
    #1;
    chk("t4_gnt",   32'(gnt),     32'h0);
    chk("t4_busy",  32'(busy),    32'h0);
    chk("t4_snd",   32'(spi_snd), 32'h0);
    chk("t4_cmplt", 32'(cmplt),   32'h0);
    chk("t4_resp",  32'(resp),    32'h0);
    mcnt = 0; spi_done = 1'b0; req = 2'b10; auto_drop = 1; mon_lat = 5;
    step();
    rst = 1'b0;
    step();
    chk("t4_regnt", 32'(gnt),     32'h2);
    chk("t4_resnd", 32'(spi_snd), 32'h1);
    wait_cmplt(40, "t4_cmplt_seen");
    chk("t4_resp2", 32'(resp), 32'h2323);
    repeat (GAP + 3) step();

    // 5: stray done while idle
    spi_done = 1'b0; step();
    r0 = resp; nc = cmp_cnt; ns = snd_cnt;
    spi_done = 1'b1; step();
    spi_done = 1'b0;
    repeat (4) step();
    chk("t5_cmplt", 32'(cmp_cnt), 32'(nc));
    chk("t5_snd",   32'(snd_cnt), 32'(ns));
    chk("t5_busy",  32'(busy),    32'h0);
    chk("t5_resp",  32'(resp),    32'(r0));

`ifdef SPI_ARB_TIMEOUT_EN
    // 6: monarch never answers
    mon_hang = 1; req = 2'b01;
    wait_snd(20, "t6_snd_seen");
    wait_cmplt(TO + 20, "t6_cmplt_seen");
    chk("t6_lat",   32'(tcyc - last_snd), 32'(TO + 1));
    chk("t6_cmplt", 32'(cmplt), 32'h1);
    chk("t6_resp",  32'(resp),  32'hFFFF);
    chk("t6_err",   32'(err),   32'h1);
    mon_hang = 0;
    repeat (GAP + 3) step();
    req = 2'b10;
    wait_cmplt(40, "t6_next_seen");
    chk("t6_resp2", 32'(resp), 32'h2323);
    chk("t6_err2",  32'(err),  32'h1);
    repeat (GAP + 3) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
